// File: rtl/demux_1_4_stream_pkg.sv
// demux_pkg: shared channel count, index width and mask types for the 1:4 stream demux.
package demux_pkg;
    localparam int N_OUT = 4;
    localparam int SEL_W = $clog2(N_OUT);
    typedef logic [SEL_W-1:0] chan_idx_t;
    typedef logic [N_OUT-1:0] chan_mask_t;
    function automatic chan_mask_t onehot(chan_idx_t i);
        return chan_mask_t'(1) << i;
    endfunction
endpackage

// File: rtl/demux_1_4_stream_if.sv
// demux_1_4_stream_if: input stream plus four per-channel output handshakes.
interface demux_1_4_stream_if
    import demux_pkg::*;
#(parameter int W = 4);
    logic [W-1:0] d;
    chan_idx_t    sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [W-1:0] y3;
    chan_mask_t   y_valid;
    chan_mask_t   y_ready;
    modport master (
        output d, sel, in_valid, y_ready,
        input  in_ready, y0, y1, y2, y3, y_valid
    );
    modport slave (
        input  d, sel, in_valid, y_ready,
        output in_ready, y0, y1, y2, y3, y_valid
    );
endinterface

// File: rtl/demux_1_4_stream_slot.sv
// demux_slot: one-entry output register; a load wins over a drain so a full slot can refill every cycle.
module demux_slot #(parameter int W = 4) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         can_load
);
    assign can_load = !out_valid || out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: steers each accepted word into the one-entry slot of the indexed output channel.
module demux_1_4_stream
    import demux_pkg::*;
#(parameter int W = 4) (
    input logic clk,
    input logic rst_n,
    demux_1_4_stream_if.slave bus
);
    chan_mask_t   can_load;
    chan_mask_t   load;
    logic         accept;
    logic [W-1:0] ydata [N_OUT];
    // in_ready looks only at the addressed slot, so a stalled channel blocks nothing else
    assign bus.in_ready = can_load[bus.sel];
    assign accept       = bus.in_valid && bus.in_ready;
    assign load         = {N_OUT{accept}} & onehot(bus.sel);
    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_slot #(.W(W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[g]),
            .load_data (bus.d),
            .out_ready (bus.y_ready[g]),
            .out_valid (bus.y_valid[g]),
            .out_data  (ydata[g]),
            .can_load  (can_load[g])
        );
    end
    assign bus.y0 = ydata[0];
    assign bus.y1 = ydata[1];
    assign bus.y2 = ydata[2];
    assign bus.y3 = ydata[3];
    sel_known: assert property (@(posedge clk) disable iff (!rst_n) bus.in_valid |-> !$isunknown(bus.sel));
endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb_demux_1_4_stream: table-driven directed checks plus hand sequences for throughput, stall, reset and X data.
module tb_demux_1_4_stream;
    import demux_pkg::*;
    typedef struct {
        logic [3:0]  d;
        logic [1:0]  sel;
        logic        v;
        logic [3:0]  yr;
        logic        ir;
        logic [3:0]  yv;
        logic [15:0] yy;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    demux_1_4_stream_if #(.W(4)) bus ();
    demux_1_4_stream #(.W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic chk_out(input string name, input logic [3:0] yv, input logic [15:0] yy);
        chk({name, " y_valid"}, 32'(bus.y_valid), 32'(yv));
        chk({name, " y"}, 32'({bus.y3, bus.y2, bus.y1, bus.y0}), 32'(yy));
    endtask
    // called just after a falling edge: drive, check in_ready, take the edge, check outputs
    task automatic step(input string name, input vec_t t);
        bus.d = t.d;
        bus.sel = t.sel;
        bus.in_valid = t.v;
        bus.y_ready = t.yr;
        #1 chk({name, " in_ready"}, 32'(bus.in_ready), 32'(t.ir));
        @(posedge clk);
        #1 chk_out(name, t.yv, t.yy);
        @(negedge clk);
    endtask
    vec_t tbl [12];
    logic [3:0] xv;
    initial begin
        tbl[0]  = '{4'hA, 2'd0, 1'b1, 4'hF, 1'b1, 4'h1, 16'h000A};
        tbl[1]  = '{4'hB, 2'd1, 1'b1, 4'hF, 1'b1, 4'h2, 16'h00BA};
        tbl[2]  = '{4'hC, 2'd2, 1'b1, 4'hF, 1'b1, 4'h4, 16'h0CBA};
        tbl[3]  = '{4'hD, 2'd3, 1'b1, 4'hF, 1'b1, 4'h8, 16'hDCBA};
        tbl[4]  = '{4'h0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h0, 16'hDCBA};
        tbl[5]  = '{4'h7, 2'd0, 1'b1, 4'hE, 1'b1, 4'h1, 16'hDCB7};
        tbl[6]  = '{4'hA, 2'd0, 1'b1, 4'hE, 1'b0, 4'h1, 16'hDCB7};
        tbl[7]  = '{4'h3, 2'd2, 1'b1, 4'hE, 1'b1, 4'h5, 16'hD3B7};
        tbl[8]  = '{4'h0, 2'd0, 1'b0, 4'hE, 1'b0, 4'h1, 16'hD3B7};
        tbl[9]  = '{4'h0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h0, 16'hD3B7};
        tbl[10] = '{4'h5, 2'd1, 1'b1, 4'h0, 1'b1, 4'h2, 16'hD357};
        tbl[11] = '{4'h9, 2'd1, 1'b1, 4'h2, 1'b1, 4'h2, 16'hD397};
        bus.d = '0;
        bus.sel = '0;
        bus.in_valid = 1'b0;
        bus.y_ready = '0;
        #1 chk_out("reset", 4'h0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step($sformatf("vec%0d", i), tbl[i]);
        for (int k = 1; k <= 8; k++)
            step($sformatf("b2b%0d", k), '{4'(k), 2'd1, 1'b1, 4'h2, 1'b1, 4'h2, {12'hD30 | 12'(k), 4'h7}});
        step("drain", '{4'h0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h0, 16'hD387});
        step("fill0", '{4'h1, 2'd0, 1'b1, 4'h0, 1'b1, 4'h1, 16'hD381});
        step("fill1", '{4'h2, 2'd1, 1'b1, 4'h0, 1'b1, 4'h3, 16'hD321});
        step("fill2", '{4'h3, 2'd2, 1'b1, 4'h0, 1'b1, 4'h7, 16'hD321});
        step("fill3", '{4'h4, 2'd3, 1'b1, 4'h0, 1'b1, 4'hF, 16'h4321});
        for (int c = 0; c < 5; c++)
            step($sformatf("hold%0d", c), '{4'hF, 2'(c), 1'b1, 4'h0, 1'b0, 4'hF, 16'h4321});
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 4'h0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", '{4'h6, 2'd3, 1'b1, 4'hF, 1'b1, 4'h8, 16'h6000});
        step("load0", '{4'h4, 2'd0, 1'b1, 4'hF, 1'b1, 4'h1, 16'h6004});
        xv = 'x;
        bus.d = xv;
        bus.sel = 2'd3;
        bus.in_valid = 1'b1;
        bus.y_ready = 4'hF;
        #1 chk("xdata in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 chk("xdata y_valid", 32'(bus.y_valid), 32'h8);
        chk("xdata y3", 32'(bus.y3), 32'(xv));
        chk("xdata y0..y2", 32'({bus.y2, bus.y1, bus.y0}), 32'h004);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
